// File: rtl/eth_pkg.sv
// Shared Ethernet constants, receive FSM state type and the byte-wise CRC-32 step.
// Used by the GMII receive MAC and the CRC engine that the TX path also uses.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        DROP     = 2'd0,
        IDLE     = 2'd1,
        PREAMBLE = 2'd2,
        DATA     = 2'd3
    } rx_state_e;

    // Reflected CRC-32, one byte consumed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int k = 0; k < 8; k++) begin
            if (c[0] ^ data[k]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wise registered CRC-32 (reflected, no final inversion); o_crc holds the running
// register, so a frame checked through its FCS leaves the fixed residue behind.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_crc <= CRC32_INIT;
        end else if (i_clear) begin
            o_crc <= CRC32_INIT;
        end else if (i_en) begin
            o_crc <= crc32_byte(o_crc, i_data);
        end
    end

endmodule

// File: rtl/gmii_rx_mac.sv
// GMII receive MAC: strips preamble/SFD and FCS, checks CRC/length/PHY error, flags frames.
// Optional saturating frame statistics counters when GMII_RX_STATS_EN is defined.
//
// state    | meaning
// DROP     | waiting for rx_dv low so we never lock onto a frame already in flight
// IDLE     | between frames, looking for preamble or SFD
// PREAMBLE | inside 0x55 run, waiting for SFD
// DATA     | frame body: CRC, length, error flag, 5-byte delay line to hide FCS
module gmii_rx_mac
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_dv,
    input  logic        i_rx_er,
    input  logic [7:0]  i_rx_d,
    output logic [7:0]  o_tdata,
    output logic        o_tvalid,
    output logic        o_tlast,
    output logic        o_tuser,
    output logic        o_frame_good,
    output logic        o_frame_bad,
    output logic        o_preamble_err
`ifdef GMII_RX_STATS_EN
    ,
    output logic [31:0] o_good_count,
    output logic [31:0] o_bad_count,
    output logic [31:0] o_preamble_err_count
`endif
);

    localparam int LEN_W = $clog2(MAX_FRAME_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME_LEN + 1);
    localparam logic [2:0]       DLY_DEPTH = 3'd5;

    rx_state_e        state;
    logic [7:0]       dly [5];
    logic [2:0]       fill;
    logic [LEN_W-1:0] len;
    logic             er_seen;
    logic [31:0]      crc;
    logic             sfd_hit;
    logic             crc_en;
    logic             frame_bad;

    always_comb begin
        sfd_hit   = i_rx_dv && (i_rx_d == SFD_BYTE) && ((state == IDLE) || (state == PREAMBLE));
        crc_en    = i_rx_dv && (state == DATA);
        frame_bad = (crc != CRC32_RESIDUE) || er_seen || (len < LEN_MIN) || (len > LEN_MAX);
    end

    eth_crc32 u_crc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (sfd_hit),
        .i_en    (crc_en),
        .i_data  (i_rx_d),
        .o_crc   (crc)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= DROP;
            fill           <= '0;
            len            <= '0;
            er_seen        <= 1'b0;
            for (int k = 0; k < 5; k++) dly[k] <= '0;
            o_tdata        <= '0;
            o_tvalid       <= 1'b0;
            o_tlast        <= 1'b0;
            o_tuser        <= 1'b0;
            o_frame_good   <= 1'b0;
            o_frame_bad    <= 1'b0;
            o_preamble_err <= 1'b0;
        end else begin
            o_tvalid       <= 1'b0;
            o_tlast        <= 1'b0;
            o_tuser        <= 1'b0;
            o_frame_good   <= 1'b0;
            o_frame_bad    <= 1'b0;
            o_preamble_err <= 1'b0;

            if (sfd_hit) begin
                fill    <= '0;
                len     <= '0;
                er_seen <= 1'b0;
                for (int k = 0; k < 5; k++) dly[k] <= '0;
            end

            case (state)
                DROP: begin
                    if (!i_rx_dv) state <= IDLE;
                end
                IDLE: begin
                    if (i_rx_dv) begin
                        if (i_rx_d == PREAMBLE_BYTE) begin
                            state <= PREAMBLE;
                        end else if (i_rx_d == SFD_BYTE) begin
                            state <= DATA;
                        end else begin
                            o_preamble_err <= 1'b1;
                            state          <= DROP;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!i_rx_dv) begin
                        o_preamble_err <= 1'b1;
                        state          <= IDLE;
                    end else if (i_rx_d == SFD_BYTE) begin
                        state <= DATA;
                    end else if (i_rx_d != PREAMBLE_BYTE) begin
                        o_preamble_err <= 1'b1;
                        state          <= DROP;
                    end
                end
                DATA: begin
                    if (i_rx_dv) begin
                        if (len != LEN_SAT) len <= len + LEN_W'(1);
                        if (i_rx_er) er_seen <= 1'b1;
                        dly[0] <= i_rx_d;
                        for (int k = 1; k < 5; k++) dly[k] <= dly[k-1];
                        if (fill == DLY_DEPTH) begin
                            o_tvalid <= 1'b1;
                            o_tdata  <= dly[4];
                        end else begin
                            fill <= fill + 3'd1;
                        end
                    end else begin
                        // The four youngest held bytes are the FCS; only the oldest is payload.
                        if (fill == DLY_DEPTH) begin
                            o_tvalid <= 1'b1;
                            o_tdata  <= dly[4];
                            o_tlast  <= 1'b1;
                            o_tuser  <= frame_bad;
                        end
                        o_frame_good <= !frame_bad;
                        o_frame_bad  <= frame_bad;
                        state        <= IDLE;
                    end
                end
                default: state <= DROP;
            endcase
        end
    end

`ifdef GMII_RX_STATS_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_good_count         <= '0;
            o_bad_count          <= '0;
            o_preamble_err_count <= '0;
        end else begin
            if (o_frame_good && (o_good_count != '1)) o_good_count <= o_good_count + 32'd1;
            if (o_frame_bad && (o_bad_count != '1)) o_bad_count <= o_bad_count + 32'd1;
            if (o_preamble_err && (o_preamble_err_count != '1)) begin
                o_preamble_err_count <= o_preamble_err_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gmii_rx_mac.sv
// Directed bench for gmii_rx_mac: table of frames plus hand-written preamble-error,
// back-to-back and mid-frame reset sequences; expected FCS and payload built locally.
module tb_gmii_rx_mac;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;
    logic [7:0] rx_d = 8'h00;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser, frame_good, frame_bad, preamble_err;

    gmii_rx_mac dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_rx_dv        (rx_dv),
        .i_rx_er        (rx_er),
        .i_rx_d         (rx_d),
        .o_tdata        (tdata),
        .o_tvalid       (tvalid),
        .o_tlast        (tlast),
        .o_tuser        (tuser),
        .o_frame_good   (frame_good),
        .o_frame_bad    (frame_bad),
        .o_preamble_err (preamble_err)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] data_q[$];
    int         cyc_q[$];
    bit         last_q[$];
    bit         user_q[$];
    int         good_q[$];
    int         bad_q[$];
    int         perr_q[$];
    int b_data, b_good, b_bad, b_perr;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (tvalid) begin
            data_q.push_back(tdata);
            cyc_q.push_back(cyc);
            last_q.push_back(tlast);
            user_q.push_back(tuser);
        end
        if (frame_good) good_q.push_back(cyc);
        if (frame_bad) bad_q.push_back(cyc);
        if (preamble_err) perr_q.push_back(cyc);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mark();
        b_data = data_q.size();
        b_good = good_q.size();
        b_bad  = bad_q.size();
        b_perr = perr_q.size();
    endtask

    function automatic logic [7:0] pat(input int i, input int seed);
        return 8'(i * seed + seed - 1);
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int k = 0; k < 8; k++) begin
            if (c[0] != b[k]) c = {1'b0, c[31:1]} ^ 32'hEDB88320;
            else c = {1'b0, c[31:1]};
        end
        return c;
    endfunction

    task automatic drive(input bit dv, input logic [7:0] d);
        @(negedge clk);
        rx_dv = dv;
        rx_d  = d;
        rx_er = 1'b0;
    endtask

    task automatic send(input int plen, input int seed, input int npre, input bit add_fcs,
                        input bit flip, input int er_idx, input int idle_n, input int rst_at,
                        output int n0, output int tot);
        logic [7:0]  fr[$];
        logic [31:0] c;
        logic [31:0] fcs;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) begin
            fr.push_back(pat(i, seed));
            c = crc_upd(c, pat(i, seed));
        end
        if (add_fcs) begin
            fcs = ~c;
            fr.push_back(fcs[7:0]);
            fr.push_back(fcs[15:8]);
            fr.push_back(fcs[23:16]);
            fr.push_back(fcs[31:24]);
            if (flip) fr[plen] = fr[plen] ^ 8'h01;
        end
        tot = fr.size();
        n0 = 0;
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < tot; i++) begin
            @(negedge clk);
            rx_dv = 1'b1;
            rx_d  = fr[i];
            rx_er = (i == er_idx);
            if (i == 0) n0 = cyc + 1;
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk("reset_outputs_zero",
                    {tvalid, tlast, tuser, frame_good, frame_bad, preamble_err, tdata}, 0);
                mark();
            end
            if (rst_at >= 0 && i == rst_at + 2) rst = 1'b0;
        end
        // rx_er on the end cycle must not matter
        for (int i = 0; i < idle_n; i++) begin
            @(negedge clk);
            rx_dv = 1'b0;
            rx_d  = 8'h00;
            rx_er = (i == 0);
        end
    endtask

    task automatic check_frame(input string nm, input int seed, input int exp_n, input bit exp_bad,
                               input int exp_perr, input int n0, input int tot);
        int n, mism, nl, lpos;
        n = data_q.size() - b_data;
        chk({nm, "_count"}, n, exp_n);
        mism = 0;
        for (int i = 0; i < n && i < exp_n; i++) begin
            if (data_q[b_data + i] != pat(i, seed)) mism++;
        end
        chk({nm, "_data_mismatches"}, mism, 0);
        nl = 0;
        lpos = -1;
        for (int i = 0; i < n; i++) begin
            if (last_q[b_data + i]) begin
                nl++;
                lpos = i;
            end
        end
        chk({nm, "_tlast_count"}, nl, (exp_n > 0) ? 1 : 0);
        if (exp_n > 0 && n > 0) begin
            chk({nm, "_tlast_pos"}, lpos, exp_n - 1);
            if (lpos >= 0) chk({nm, "_tuser"}, user_q[b_data + lpos], exp_bad);
            chk({nm, "_first_cycle"}, cyc_q[b_data], n0 + 5);
            chk({nm, "_last_cycle"}, cyc_q[b_data + n - 1], n0 + tot);
        end
        chk({nm, "_good_pulses"}, good_q.size() - b_good, exp_bad ? 0 : 1);
        chk({nm, "_bad_pulses"}, bad_q.size() - b_bad, exp_bad ? 1 : 0);
        if (exp_bad && bad_q.size() > b_bad) chk({nm, "_bad_cycle"}, bad_q[b_bad], n0 + tot);
        if (!exp_bad && good_q.size() > b_good) chk({nm, "_good_cycle"}, good_q[b_good], n0 + tot);
        chk({nm, "_preamble_err"}, perr_q.size() - b_perr, exp_perr);
    endtask

    typedef struct {
        string nm;
        int    plen;
        int    seed;
        int    npre;
        bit    fcs;
        bit    flip;
        int    er;
        int    exp_n;
        bit    bad;
        int    idle;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n0, tot, pc;

        tbl[0] = '{"good60",    60,   1, 7, 1, 0, -1, 60,   0, 3};
        tbl[1] = '{"badfcs",    60,   1, 7, 1, 1, -1, 60,   1, 3};
        tbl[2] = '{"rxer10",    60,   3, 7, 1, 0, 10, 60,   1, 3};
        tbl[3] = '{"three",     3,    5, 7, 0, 0, -1, 0,    1, 3};
        tbl[4] = '{"over1519",  1515, 1, 7, 1, 0, -1, 1515, 1, 3};
        tbl[5] = '{"max1518",   1514, 1, 7, 1, 0, -1, 1514, 0, 3};
        tbl[6] = '{"runt63",    59,   9, 7, 1, 0, -1, 59,   1, 3};
        tbl[7] = '{"five",      1,    2, 7, 1, 0, -1, 1,    1, 3};
        tbl[8] = '{"nopre_b2b", 100,  7, 0, 1, 0, -1, 100,  0, 1};
        tbl[9] = '{"b2b_next",  200, 11, 3, 1, 0, -1, 200,  0, 3};

        #3 rst = 1'b1;
        #20;
        chk("reset_state_outputs",
            {tvalid, tlast, tuser, frame_good, frame_bad, preamble_err, tdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_idle_outputs",
            {tvalid, tlast, tuser, frame_good, frame_bad, preamble_err, tdata}, 0);

        for (int v = 0; v < 10; v++) begin
            mark();
            send(tbl[v].plen, tbl[v].seed, tbl[v].npre, tbl[v].fcs, tbl[v].flip, tbl[v].er,
                 tbl[v].idle, -1, n0, tot);
            @(posedge clk);
            #2;
            check_frame(tbl[v].nm, tbl[v].seed, tbl[v].exp_n, tbl[v].bad, 0, n0, tot);
        end

        // 0x55,0x57 malformed preamble followed by an SFD-like tail that must be ignored
        mark();
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h57);
        pc = cyc + 1;
        drive(1'b1, 8'hD5);
        for (int i = 1; i < 6; i++) drive(1'b1, 8'(i));
        drive(1'b0, 8'h00);
        send(60, 1, 7, 1, 0, -1, 3, -1, n0, tot);
        @(posedge clk);
        #2;
        check_frame("after_perr57", 1, 60, 0, 1, n0, tot);
        if (perr_q.size() > b_perr) chk("perr57_cycle", perr_q[b_perr], pc);

        // preamble cut short by rx_dv low, next frame straight after
        mark();
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        drive(1'b0, 8'h00);
        pc = cyc + 1;
        send(64, 13, 5, 1, 0, -1, 3, -1, n0, tot);
        @(posedge clk);
        #2;
        check_frame("after_perr_dv", 13, 64, 0, 1, n0, tot);
        if (perr_q.size() > b_perr) chk("perr_dv_cycle", perr_q[b_perr], pc);

        // junk byte in IDLE
        mark();
        drive(1'b1, 8'h12);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h00);
        send(60, 1, 7, 1, 0, -1, 3, -1, n0, tot);
        @(posedge clk);
        #2;
        check_frame("after_perr_idle", 1, 60, 0, 1, n0, tot);

        // reset at payload byte 20, released with rx_dv still high
        send(60, 1, 7, 1, 0, -1, 3, 20, n0, tot);
        @(posedge clk);
        #2;
        chk("rst_mid_bytes_after", data_q.size() - b_data, 0);
        chk("rst_mid_good_after", good_q.size() - b_good, 0);
        chk("rst_mid_bad_after", bad_q.size() - b_bad, 0);
        chk("rst_mid_perr_after", perr_q.size() - b_perr, 0);
        mark();
        send(60, 1, 7, 1, 0, -1, 3, -1, n0, tot);
        @(posedge clk);
        #2;
        check_frame("after_reset", 1, 60, 0, 0, n0, tot);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gmii_rx_mac.md
# gmii_rx_mac

Receive-side byte MAC for the 1G Ethernet port: consumes the 8-bit GMII receive stream produced by the RGMII DDR capture and emits frame payload as a valid-only byte stream. It strips preamble/SFD, checks FCS (CRC-32), length and PHY error, removes the 4 FCS bytes, and flags each frame good or bad on its last byte. It sits between the RGMII input stage and the packet consumer, alongside the TX path driving the PHY.

## Interface
- MIN_FRAME_LEN, 64, minimum legal length, SFD excluded, FCS included
- MAX_FRAME_LEN, 1518, maximum legal length, FCS included
- i_clk  in  1  125 MHz GMII RX clock
- i_reset  in  1  asynchronous, active-high reset
- i_rx_dv  in  1  GMII data valid
- i_rx_er  in  1  GMII receive error
- i_rx_d  in  8  GMII receive byte
- o_tdata  out  8  payload byte
- o_tvalid  out  1  payload byte valid; no backpressure
- o_tlast  out  1  last payload byte of frame
- o_tuser  out  1  frame bad; meaningful only with o_tlast
- o_frame_good  out  1  one-cycle pulse, frame accepted
- o_frame_bad  out  1  one-cycle pulse, frame rejected (FCS, i_rx_er, runt, oversize)
- o_preamble_err  out  1  one-cycle pulse, malformed preamble/SFD

## Operation
- States: DROP, IDLE, PREAMBLE, DATA. Reset state is DROP.
- DROP: wait for i_rx_dv=0, then go to IDLE. This prevents locking onto a frame already in progress.
- IDLE: when i_rx_dv=1:
  - byte 0x55 -> PREAMBLE
  - byte 0xD5 -> DATA
  - any other byte -> DROP, with an o_preamble_err pulse
- PREAMBLE: 0x55 stays; 0xD5 -> DATA; any other byte, or i_rx_dv=0 -> o_preamble_err pulse, then DROP (or IDLE if i_rx_dv=0). The preamble byte count is not checked.
- DATA, per byte with i_rx_dv=1:
  - update CRC (reflected poly 0xEDB88320, init 0xFFFFFFFF, LSB first)
  - increment length counter, saturating at MAX_FRAME_LEN+1
  - if i_rx_er=1, latch the error flag
  - push the byte into a 5-deep delay line
  - once the line holds 5 bytes, each new byte pushes out the oldest, which is emitted with o_tvalid=1, o_tlast=0
- DATA end (first i_rx_dv=0):
  - the oldest of the 5 held bytes is the last payload byte; emit it with o_tlast=1. The other 4 are FCS and are discarded.
  - bad = (CRC register ≠ 0xDEBB20E3) | error flag | len<MIN_FRAME_LEN | len>MAX_FRAME_LEN
  - o_tuser=bad; pulse o_frame_good=!bad or o_frame_bad=bad; go to IDLE
- Fewer than 5 bytes after SFD: no stream output, o_frame_bad pulse only.
- Outputs are registered. Reset values of all outputs are 0. The delay line, CRC and counters are cleared on reset and on each SFD.

## Timing
- Byte n after SFD is sampled in cycle c_n and appears on o_tdata in cycle c_{n+5}+1.
- o_tlast, o_tuser and the good/bad pulse appear one cycle after the first i_rx_dv=0 sample.
- o_tvalid is contiguous within a frame except for gaps in i_rx_dv; any i_rx_dv=0 ends the frame.
- Back-to-back: a new preamble may be sampled in the cycle immediately after the end cycle. IDLE handles it with no lost byte.
- i_rx_er with i_rx_dv=0 is ignored. i_rx_er in the end cycle is ignored.
- Reset mid-frame: outputs drop to 0 immediately with no o_tlast; the block re-enters DROP.

## Configuration
- GMII_RX_STATS_EN defined:
  - adds o_good_count[31:0], o_bad_count[31:0] and o_preamble_err_count[31:0]
  - each counter is saturating, increments on its pulse, and is cleared by reset
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- eth_pkg holds:
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3
  - the state enum
- Sub-module eth_crc32: byte-wise registered CRC with i_clear/i_en/i_data and o_crc. It is shared with the TX path.

## Test plan
- 7×0x55, 0xD5, payload 0x00..0x3B (60 bytes), correct FCS -> 60 bytes out, o_tlast on 0x3B, o_tuser=0, o_frame_good pulse.
- Same frame with FCS byte 0 XOR 0x01 -> identical payload, o_tuser=1, o_frame_bad pulse.
- i_rx_er=1 on payload byte 10 of a valid 64-byte frame -> o_tuser=1, o_frame_bad; and 3 bytes after SFD -> no o_tvalid, o_frame_bad only.
- 1519-byte frame with valid FCS -> 1515 bytes out, o_tuser=1; 1518-byte frame -> o_tuser=0.
- Preamble 0x55,0x57 -> o_preamble_err pulse, no output until i_rx_dv low; next good frame, starting one cycle later, is received correctly.
- i_reset asserted at payload byte 20, released with i_rx_dv still high -> outputs 0, nothing emitted for the remainder; next frame is received good.
